// File: rtl/activation_unit_if.sv
// activation_unit_if
//   Control/status bundle for the activation stage.
//   in_start  : start request (sampled by the stage only while idle)
//   in_mode   : 0 pass, 1 ReLU, 2 leaky ReLU, 3 clamped ReLU
//   in_shift  : leaky right-shift amount
//   in_clamp  : clamp ceiling (non-negative)
//   out_busy  : run in progress
//   out_done  : one-cycle completion pulse
//   master drives the requests, slave (the stage) drives busy/done.
interface activation_unit_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  in_start;
  logic [1:0]            in_mode;
  logic [4:0]            in_shift;
  logic [DATA_WIDTH-1:0] in_clamp;
  logic                  out_busy;
  logic                  out_done;

  modport master (
    output in_start, in_mode, in_shift, in_clamp,
    input  out_busy, out_done
  );

  modport slave (
    input  in_start, in_mode, in_shift, in_clamp,
    output out_busy, out_done
  );
endinterface

// File: rtl/activation_unit.sv
// activation_unit
//   Sweeps a source buffer once per start, applies the selected activation
//   function to every signed word and writes the result to the destination
//   buffer at the same address, then pulses done.
//   Ports:
//     clk, rst     : clock, asynchronous active-high reset
//     axisif       : control/status bundle (start, mode, shift, clamp, busy, done)
//     out_adrIn    : source read address
//     in_dataIn    : source read data, valid RD_LAT cycles after the address
//     out_adrOut   : destination write address (equals source address)
//     out_dataOut  : destination write data
//     out_wr       : destination write strobe
//   The interface instance must use the same DATA_WIDTH as this module.
module activation_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int DATA_NUM   = 16,
  parameter int ADR_WIDTH  = 4,
  parameter int RD_LAT     = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  activation_unit_if.slave      axisif,
  output logic [ADR_WIDTH-1:0]  out_adrIn,
  input  logic [DATA_WIDTH-1:0] in_dataIn,
  output logic [ADR_WIDTH-1:0]  out_adrOut,
  output logic [DATA_WIDTH-1:0] out_dataOut,
  output logic                  out_wr
);

  localparam logic [ADR_WIDTH-1:0] LAST_ADR = ADR_WIDTH'(DATA_NUM - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t state_q, state_d;
  logic   start_acc;

  logic [1:0]            mode_q;
  logic [4:0]            shift_q;
  logic [DATA_WIDTH-1:0] clamp_q;
  logic [ADR_WIDTH-1:0]  adr_in_q;
  logic [ADR_WIDTH-1:0]  adr_out_q;
  logic [DATA_WIDTH-1:0] data_out_q;
  logic                  wr_q;

  logic                  issue_vld;
  logic                  tap_vld;
  logic [ADR_WIDTH-1:0]  tap_adr;
  logic [DATA_WIDTH-1:0] act;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    start_acc = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (axisif.in_start) begin
          state_d   = S_RUN;
          start_acc = 1'b1;
        end
      end
      S_RUN: begin
        if (adr_in_q == LAST_ADR) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        // Only one write per run carries the last address, so it marks the end.
        if (wr_q && (adr_out_q == LAST_ADR)) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign axisif.out_busy = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign axisif.out_done = (state_q == S_DONE);
  assign issue_vld       = (state_q == S_RUN);

  // ------------------------------------------------- address + run config
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      adr_in_q <= '0;
      mode_q   <= '0;
      shift_q  <= '0;
      clamp_q  <= '0;
    end else if (start_acc) begin
      adr_in_q <= '0;
      mode_q   <= axisif.in_mode;
      shift_q  <= axisif.in_shift;
      clamp_q  <= axisif.in_clamp;
    end else if ((state_q == S_RUN) && (adr_in_q != LAST_ADR)) begin
      adr_in_q <= adr_in_q + ADR_WIDTH'(1);
    end
  end

  // ---------------------------------------- read-latency alignment pipe
  // Carries {valid, address} alongside the memory's read latency so the
  // write address always matches the data that arrives.
  generate
    if (RD_LAT == 0) begin : g_nolat
      assign tap_vld = issue_vld;
      assign tap_adr = adr_in_q;
    end else begin : g_lat
      logic                 vld_q [RD_LAT];
      logic [ADR_WIDTH-1:0] padr_q[RD_LAT];
      for (genvar gi = 0; gi < RD_LAT; gi++) begin : g_stage
        if (gi == 0) begin : g_first
          always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
              vld_q[gi]  <= 1'b0;
              padr_q[gi] <= '0;
            end else begin
              vld_q[gi]  <= issue_vld;
              padr_q[gi] <= adr_in_q;
            end
          end
        end else begin : g_next
          always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
              vld_q[gi]  <= 1'b0;
              padr_q[gi] <= '0;
            end else begin
              vld_q[gi]  <= vld_q[gi-1];
              padr_q[gi] <= padr_q[gi-1];
            end
          end
        end
      end
      assign tap_vld = vld_q[RD_LAT-1];
      assign tap_adr = padr_q[RD_LAT-1];
    end
  endgenerate

  // ------------------------------------------------ activation function
  always_comb begin
    logic signed [DATA_WIDTH-1:0] x;
    x   = $signed(in_dataIn);
    act = x;
    case (mode_q)
      2'd0: act = x;
      2'd1: act = x[DATA_WIDTH-1] ? '0 : x;
      // >>> on a signed operand floors toward -inf and saturates to -1
      // once the shift reaches the word width.
      2'd2: act = x[DATA_WIDTH-1] ? DATA_WIDTH'(x >>> shift_q) : x;
      2'd3: begin
        // x is known non-negative here, so an unsigned compare is exact.
        if (x[DATA_WIDTH-1])        act = '0;
        else if ($unsigned(x) > clamp_q) act = clamp_q;
        else                        act = x;
      end
      default: act = x;
    endcase
  end

  // ------------------------------------------------- registered write port
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q       <= 1'b0;
      adr_out_q  <= '0;
      data_out_q <= '0;
    end else begin
      wr_q <= tap_vld;
      if (tap_vld) begin
        adr_out_q  <= tap_adr;
        data_out_q <= act;
      end
    end
  end

  assign out_adrIn   = adr_in_q;
  assign out_adrOut  = adr_out_q;
  assign out_dataOut = data_out_q;
  assign out_wr      = wr_q;

endmodule

// File: doc/activation_unit.md
# activation_unit

Parametrised, mode-selectable activation stage for the CNN datapath. On a start pulse it sweeps a source buffer sequentially, applies one of four activation functions to each signed word, and writes the results to a destination buffer at the same address, then pulses done. It generalises the single-function ReLU stage: selectable mode, runtime leaky shift and clamp ceiling, and a configurable source-memory read latency.

## Interface
- DATA_WIDTH, 32, word width; two's-complement signed
- DATA_NUM, 16, words per run; any value 1..2^ADR_WIDTH, power of two not required
- ADR_WIDTH, 4, address width; ADR_WIDTH ≥ clog2(DATA_NUM)
- RD_LAT, 0, source read latency in cycles (0..3); 0 means in_dataIn is combinational from out_adrIn
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- axisif_in_start  in  1  start request, sampled only in IDLE
- axisif_in_mode  in  2  0 pass, 1 ReLU, 2 leaky ReLU, 3 clamped ReLU; latched at start
- axisif_in_shift  in  5  leaky right-shift amount; latched at start
- axisif_in_clamp  in  DATA_WIDTH  clamp ceiling, treated as non-negative signed; latched at start
- axisif_out_busy  out  1  high from first address cycle through last write cycle
- axisif_out_done  out  1  one-cycle completion pulse
- out_adrIn  out  ADR_WIDTH  source read address
- in_dataIn  in  DATA_WIDTH  source read data
- out_adrOut  out  ADR_WIDTH  destination write address
- out_dataOut  out  DATA_WIDTH  destination write data
- out_wr  out  1  destination write strobe

## Operation
- FSM: IDLE -> RUN (start=1 in IDLE) -> DRAIN (last address issued) -> DONE (last write issued) -> IDLE.
- RUN: out_adrIn starts at 0 and increments once per cycle up to DATA_NUM-1; no wrap. In DRAIN/DONE/IDLE it holds its last value.
- Read pipeline: RD_LAT-deep shift register carries {valid, address}; data for address a is valid RD_LAT cycles after out_adrIn=a.
- Function on signed x: mode 0 y=x; mode 1 y = x<0 ? 0 : x; mode 2 y = x<0 ? x>>>shift : x (arithmetic, floor toward -inf); mode 3 y = x<0 ? 0 : (x>clamp ? clamp : x).
- shift ≥ DATA_WIDTH in mode 2 yields -1 for negative x.
- Result, address and strobe registered once; out_adrOut equals source address.
- Start while busy or in DONE ignored; mode/shift/clamp changes mid-run ignored.
- rst asserted any time: FSM to IDLE, pipeline valids cleared, run aborted, no further writes.

## Timing
- Reset values: out_adrIn=0, out_adrOut=0, out_dataOut=0, out_wr=0, busy=0, done=0.
- Cycle 0: edge samples start=1. Cycle 1: busy=1, out_adrIn=0. Cycle k+1: out_adrIn=k.
- Write for address a: out_wr=1 in cycle a+2+RD_LAT; one write per cycle, contiguous, DATA_NUM writes total.
- Last write in cycle DATA_NUM+1+RD_LAT; busy falls after it; done=1 in cycle DATA_NUM+2+RD_LAT only.
- Start accepted again from the cycle after done; back-to-back runs give one idle cycle minimum.
- DATA_NUM=1: single address, single write, done in cycle 3+RD_LAT.

## Test plan
- RD_LAT=0, DATA_NUM=16, memory model in_dataIn=out_adrIn-8, mode 1 -> writes 0 at addresses 0..8, then 1..7 at 9..15; done in cycle 18.
- Same memory, mode 2, shift=2 -> address 0 (-8) writes -2, address 7 (-1) writes -1, address 15 writes 7.
- Mode 3, clamp=6 -> address 15 (7) writes 6, address 14 writes 6, address 13 writes 5, negatives write 0.
- RD_LAT=2, mode 0 -> first out_wr in cycle 4 with out_adrOut=0, data -8; done in cycle 20; no gaps in writes.
- DATA_NUM=10, ADR_WIDTH=4 -> out_adrIn stops at 9, exactly 10 writes; start pulsed mid-run and mode toggled mid-run -> ignored, results unchanged.
- rst pulsed at cycle 6 of a run -> all outputs 0 asynchronously, no writes or done afterwards; fresh start then completes normally.
